// File: rtl/sonar_envio_ascii_if.sv
// ============================================================================
// Module   : sonar_envio_ascii_if
// Purpose  : Request and serial-line bundle for the sonar ASCII UART sender.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sonar_envio_ascii_if;
    logic        partida;
    logic [11:0] angulo;
    logic [11:0] distancia;
    logic        saida_serial;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;

    modport master (
        output partida, angulo, distancia,
        input  saida_serial, ocupado, pronto, db_estado
    );

    modport slave (
        input  partida, angulo, distancia,
        output saida_serial, ocupado, pronto, db_estado
    );
endinterface

`default_nettype wire

// File: rtl/sonar_envio_ascii.sv
// ============================================================================
// Module   : sonar_envio_ascii
// Purpose  : Sends "AAA,DDD#" over a UART line (7 data bits, 2 stop bits);
//            define SONAR_ENVIO_PARIDADE_EN to add an even-parity bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sonar_envio_ascii #(
    parameter int BAUD_DIV = 434
) (
    input  wire logic          clock,
    input  wire logic          reset,
    sonar_envio_ascii_if.slave bus
);

    localparam int TICK_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [3:0] {
        S_INICIAL  = 4'h0,
        S_CARREGA  = 4'h1,
        S_START    = 4'h2,
        S_DADOS    = 4'h3,
        S_PARIDADE = 4'h4,
        S_STOP     = 4'h5,
        S_PROXIMO  = 4'h6,
        S_FINAL    = 4'hF
    } estado_t;

    estado_t           estado_q;
    logic [TICK_W-1:0] tick_q;
    logic [2:0]        bit_q;
    logic [2:0]        char_q;
    logic [11:0]       ang_q;
    logic [11:0]       dist_q;
    logic [6:0]        dado_q;
    logic              saida_q;
    logic              ocupado_q;
    logic              pronto_q;
`ifdef SONAR_ENVIO_PARIDADE_EN
    logic              par_q;
`endif

    logic              fim_bit;
    logic [6:0]        carga0_d;
    logic [6:0]        carga_prox_d;

    function automatic logic [6:0] ascii_de(input logic [3:0] n);
        return (n <= 4'd9) ? (7'h30 + {3'b000, n}) : 7'h3F;
    endfunction

    function automatic logic [6:0] caractere(input logic [2:0]  idx,
                                             input logic [11:0] a,
                                             input logic [11:0] d);
        logic [6:0] c;
        case (idx)
            3'd0:    c = ascii_de(a[11:8]);
            3'd1:    c = ascii_de(a[7:4]);
            3'd2:    c = ascii_de(a[3:0]);
            3'd3:    c = 7'h2C;
            3'd4:    c = ascii_de(d[11:8]);
            3'd5:    c = ascii_de(d[7:4]);
            3'd6:    c = ascii_de(d[3:0]);
            default: c = 7'h23;
        endcase
        return c;
    endfunction

    // CARREGA never occupies a cycle: the character decode is folded into
    // the transitions that enter START, so the start bit follows partida.
    assign carga0_d     = caractere(3'd0, bus.angulo, bus.distancia);
    assign carga_prox_d = caractere(char_q + 3'd1, ang_q, dist_q);
    assign fim_bit      = (tick_q == TICK_W'(BAUD_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= S_INICIAL;
            tick_q    <= '0;
            bit_q     <= '0;
            char_q    <= '0;
            ang_q     <= '0;
            dist_q    <= '0;
            dado_q    <= '0;
            saida_q   <= 1'b1;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
`ifdef SONAR_ENVIO_PARIDADE_EN
            par_q     <= 1'b0;
`endif
        end else begin
            pronto_q <= 1'b0;
            if (estado_q == S_INICIAL || estado_q == S_FINAL || fim_bit)
                tick_q <= '0;
            else
                tick_q <= tick_q + TICK_W'(1);

            case (estado_q)
                S_INICIAL: begin
                    saida_q   <= 1'b1;
                    ocupado_q <= 1'b0;
                    bit_q     <= '0;
                    char_q    <= '0;
                    if (bus.partida) begin
                        ang_q     <= bus.angulo;
                        dist_q    <= bus.distancia;
                        dado_q    <= carga0_d;
                        saida_q   <= 1'b0;
                        ocupado_q <= 1'b1;
                        estado_q  <= S_START;
                    end
                end
                S_START: if (fim_bit) begin
`ifdef SONAR_ENVIO_PARIDADE_EN
                    par_q    <= ^dado_q;
`endif
                    saida_q  <= dado_q[0];
                    dado_q   <= dado_q >> 1;
                    bit_q    <= '0;
                    estado_q <= S_DADOS;
                end
                S_DADOS: if (fim_bit) begin
                    if (bit_q == 3'd6) begin
`ifdef SONAR_ENVIO_PARIDADE_EN
                        saida_q  <= par_q;
                        estado_q <= S_PARIDADE;
`else
                        saida_q  <= 1'b1;
                        estado_q <= S_STOP;
`endif
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        saida_q <= dado_q[0];
                        dado_q  <= dado_q >> 1;
                    end
                end
`ifdef SONAR_ENVIO_PARIDADE_EN
                S_PARIDADE: if (fim_bit) begin
                    saida_q  <= 1'b1;
                    estado_q <= S_STOP;
                end
`endif
                S_STOP: if (fim_bit) begin
                    estado_q <= S_PROXIMO;
                end
                // PROXIMO carries the second stop bit and picks the successor.
                S_PROXIMO: if (fim_bit) begin
                    if (char_q == 3'd7) begin
                        ocupado_q <= 1'b0;
                        pronto_q  <= 1'b1;
                        estado_q  <= S_FINAL;
                    end else begin
                        char_q   <= char_q + 3'd1;
                        dado_q   <= carga_prox_d;
                        saida_q  <= 1'b0;
                        estado_q <= S_START;
                    end
                end
                S_FINAL: begin
                    estado_q <= S_INICIAL;
                end
                default: begin
                    estado_q <= S_INICIAL;
                end
            endcase
        end
    end

    assign bus.saida_serial = saida_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.pronto       = pronto_q;
    assign bus.db_estado    = estado_q;

endmodule

`default_nettype wire
